// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle for the hazard controller. The pipeline (master) drives
// the stage tags; the controller (slave) returns the enables, flushes and forwarding selects.
interface hazard_ctrl_unit_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        rsel1, rsel2;
  logic [4:0]        idexWsel, exmemWsel, memwbWsel;
  logic              idexWEN, idexMemRead, exmemWEN, memwbWEN;
  logic              jumpBranch, ihit, dmemReq, dhit;
  logic              pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic              ifidFlush, idexFlush;
  logic [1:0]        fwdA, fwdB, hzState;
  logic [PERF_W-1:0] bubbleCnt;

  modport master (
    output rsel1, rsel2, idexWsel, idexWEN, idexMemRead, exmemWsel, exmemWEN,
           memwbWsel, memwbWEN, jumpBranch, ihit, dmemReq, dhit,
    input  pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush,
           fwdA, fwdB, hzState, bubbleCnt
  );

  modport slave (
    input  rsel1, rsel2, idexWsel, idexWEN, idexMemRead, exmemWsel, exmemWEN,
           memwbWsel, memwbWEN, jumpBranch, ihit, dmemReq, dhit,
    output pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush,
           fwdA, fwdB, hzState, bubbleCnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Five-stage pipeline hazard controller: forwarding selects, load-use / stall-only
// bubbling, branch flush (deferred until fetch completes) and data-memory wait.
module hazard_ctrl_unit #(
  parameter bit FWD_EN    = 1'b1,
  parameter bit WB_BYPASS = 1'b1,
  parameter int STALL_W   = 2,
  parameter int PERF_W    = 16
) (
  input logic               CLK,
  input logic               nRST,
  hazard_ctrl_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    STALL     = 2'b01,
    MEMWAIT   = 2'b10,
    FLUSHPEND = 2'b11
  } state_e;

  state_e             state_q, state_d, eff_st;
  logic [STALL_W-1:0] cnt_q, cnt_d, load_v;
  logic               pend_q, pend_d;
  logic [PERF_W-1:0]  bubble_q, bubble_d;
  logic               haz, mem_wait;
  logic               pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl;
  logic [1:0]         fwd_a, fwd_b;

  function automatic logic hit(input logic [4:0] rs, input logic [4:0] ws, input logic wen);
    return wen && (ws != 5'd0) && (rs == ws);
  endfunction

  logic id1, id2, ex1, ex2, mw1, mw2;
  assign id1 = hit(hz.rsel1, hz.idexWsel,  hz.idexWEN);
  assign id2 = hit(hz.rsel2, hz.idexWsel,  hz.idexWEN);
  assign ex1 = hit(hz.rsel1, hz.exmemWsel, hz.exmemWEN);
  assign ex2 = hit(hz.rsel2, hz.exmemWsel, hz.exmemWEN);
  assign mw1 = hit(hz.rsel1, hz.memwbWsel, hz.memwbWEN);
  assign mw2 = hit(hz.rsel2, hz.memwbWsel, hz.memwbWEN);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN && nRST) begin
      if (ex1)      fwd_a = 2'b01;
      else if (mw1) fwd_a = 2'b10;
      if (ex2)      fwd_b = 2'b01;
      else if (mw2) fwd_b = 2'b10;
    end
  end

  // load_v is the number of bubbles still owed after the detection cycle itself
  always_comb begin
    haz    = 1'b0;
    load_v = '0;
    if (FWD_EN) begin
      if ((id1 || id2) && hz.idexMemRead) haz = 1'b1;
    end else if (id1 || id2) begin
      haz    = 1'b1;
      load_v = STALL_W'(1);
    end else if (ex1 || ex2) begin
      haz = 1'b1;
    end else if (!WB_BYPASS && (mw1 || mw2)) begin
      haz = 1'b1;
    end
  end

  assign mem_wait = hz.dmemReq && !hz.dhit;

  // The cycle dhit arrives behaves as the interrupted state so the returning data is captured
  always_comb begin
    eff_st = state_q;
    if (state_q == MEMWAIT) begin
      if (cnt_q != '0) eff_st = STALL;
      else if (pend_q) eff_st = FLUSHPEND;
      else             eff_st = RUN;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pc_en    = 1'b0;
    ifid_en  = 1'b0;
    idex_en  = 1'b0;
    exmem_en = 1'b0;
    memwb_en = 1'b0;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    if (mem_wait) begin
      state_d = MEMWAIT;
    end else if (hz.jumpBranch || eff_st == FLUSHPEND) begin
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      cnt_d    = '0;
      if (hz.ihit) begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
        pend_d  = 1'b0;
        state_d = RUN;
      end else begin
        pend_d  = 1'b1;
        state_d = FLUSHPEND;
      end
    end else if (eff_st == STALL) begin
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      idex_fl  = 1'b1;
      cnt_d    = cnt_q - STALL_W'(1);
      state_d  = (cnt_q == STALL_W'(1)) ? RUN : STALL;
    end else if (haz) begin
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      idex_fl  = 1'b1;
      cnt_d    = load_v;
      state_d  = (load_v != '0) ? STALL : RUN;
    end else begin
      pc_en    = hz.ihit;
      ifid_en  = hz.ihit;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      state_d  = RUN;
    end
    if (!nRST) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      ifid_fl  = 1'b0;
      idex_fl  = 1'b0;
    end
  end

  assign bubble_d = (idex_fl && bubble_q != '1) ? bubble_q + PERF_W'(1) : bubble_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      bubble_q <= bubble_d;
    end
  end

  assign hz.pcEn      = pc_en;
  assign hz.ifidEn    = ifid_en;
  assign hz.idexEn    = idex_en;
  assign hz.exmemEn   = exmem_en;
  assign hz.memwbEn   = memwb_en;
  assign hz.ifidFlush = ifid_fl;
  assign hz.idexFlush = idex_fl;
  assign hz.fwdA      = fwd_a;
  assign hz.fwdB      = fwd_b;
  assign hz.hzState   = state_q;
  assign hz.bubbleCnt = bubble_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: a forwarding instance (u0) and a stall-only,
// non-bypassed instance with a narrow bubble counter (u1), checked via a scoreboard.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.PERF_W(16)) h0 ();
  hazard_ctrl_unit_if #(.PERF_W(4))  h1 ();

  hazard_ctrl_unit #(.FWD_EN(1'b1), .WB_BYPASS(1'b1), .STALL_W(2), .PERF_W(16))
    u0 (.CLK(clk), .nRST(nRST), .hz(h0));
  hazard_ctrl_unit #(.FWD_EN(1'b0), .WB_BYPASS(1'b0), .STALL_W(2), .PERF_W(4))
    u1 (.CLK(clk), .nRST(nRST), .hz(h1));

  typedef struct packed {
    logic [4:0] rsel1, rsel2, idexWsel;
    logic       idexWEN, idexMemRead;
    logic [4:0] exmemWsel;
    logic       exmemWEN;
    logic [4:0] memwbWsel;
    logic       memwbWEN, jumpBranch, ihit, dmemReq, dhit;
  } in_t;

  // en = {pc, ifid, idex, exmem, memwb}; fl = {ifidFlush, idexFlush}
  typedef struct packed {
    logic [1:0]  st;
    logic [4:0]  en;
    logic [1:0]  fl;
    logic [1:0]  fa, fb;
    logic [15:0] bub;
  } obs_t;

  typedef struct {
    int    sel;
    string nm;
    obs_t  o;
  } sb_t;

  in_t  in0, in1;
  obs_t obs0, obs1;
  sb_t  sbq[$];
  int   ntest = 0;
  int   nfail = 0;
  int unsigned mbub[2] = '{0, 0};

  assign {h0.rsel1, h0.rsel2, h0.idexWsel, h0.idexWEN, h0.idexMemRead, h0.exmemWsel, h0.exmemWEN,
          h0.memwbWsel, h0.memwbWEN, h0.jumpBranch, h0.ihit, h0.dmemReq, h0.dhit} = in0;
  assign {h1.rsel1, h1.rsel2, h1.idexWsel, h1.idexWEN, h1.idexMemRead, h1.exmemWsel, h1.exmemWEN,
          h1.memwbWsel, h1.memwbWEN, h1.jumpBranch, h1.ihit, h1.dmemReq, h1.dhit} = in1;
  assign obs0 = {h0.hzState, h0.pcEn, h0.ifidEn, h0.idexEn, h0.exmemEn, h0.memwbEn,
                 h0.ifidFlush, h0.idexFlush, h0.fwdA, h0.fwdB, h0.bubbleCnt};
  assign obs1 = {h1.hzState, h1.pcEn, h1.ifidEn, h1.idexEn, h1.exmemEn, h1.memwbEn,
                 h1.ifidFlush, h1.idexFlush, h1.fwdA, h1.fwdB, 12'd0, h1.bubbleCnt};

  localparam in_t IDLE = '0;

  function automatic in_t mk(input logic [4:0] r1, r2, idw, input logic idwen, idmr,
                             input logic [4:0] exw, input logic exwen,
                             input logic [4:0] mww, input logic mwwen,
                             input logic jb, ih, dreq, dh);
    return {r1, r2, idw, idwen, idmr, exw, exwen, mww, mwwen, jb, ih, dreq, dh};
  endfunction

  function automatic obs_t ex(input logic [1:0] st, input logic [4:0] en, input logic [1:0] fl,
                              input logic [1:0] fa, fb);
    return {st, en, fl, fa, fb, 16'd0};
  endfunction

  // Bubble expectation: value seen this cycle, then advance if this cycle bubbles.
  task automatic push_exp(input int sel, input string nm, input obs_t o);
    sb_t s;
    int unsigned mx = (sel != 0) ? 15 : 65535;
    o.bub = 16'(mbub[sel]);
    s.sel = sel; s.nm = nm; s.o = o;
    sbq.push_back(s);
    if (o.fl[0] && mbub[sel] < mx) mbub[sel]++;
  endtask

  task automatic test_reset();
    sb_t s; obs_t got;
    in0 = mk(5'd7, 5'd7, 5'd0, 0, 0, 5'd7, 1, 5'd7, 1, 1, 1, 0, 0);
    in1 = in0;
    for (int i = 0; i < 2; i++) begin
      push_exp(0, "reset_u0", ex(2'b00, 5'b00000, 2'b00, 2'b00, 2'b00));
      push_exp(1, "reset_u1", ex(2'b00, 5'b00000, 2'b00, 2'b00, 2'b00));
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        s = sbq.pop_front(); got = (s.sel != 0) ? obs1 : obs0;
        ntest++;
        if (got !== s.o) begin nfail++; $display("FAIL %s[%0d] got %h expected %h", s.nm, i, got, s.o); end
      end
    end
    @(posedge clk); #1;
    nRST = 1'b1; in0 = IDLE; in1 = IDLE;
  endtask

  task automatic test_fwd();
    in_t v[$]; obs_t e[$]; sb_t s; obs_t got;
    v.push_back(mk(0, 7, 0, 0, 0, 7, 1, 7, 1, 0, 1, 0, 0)); e.push_back(ex(0, 5'b11111, 0, 2'b00, 2'b01));
    v.push_back(mk(0, 7, 0, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0)); e.push_back(ex(0, 5'b11111, 0, 2'b00, 2'b10));
    v.push_back(mk(7, 7, 0, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0)); e.push_back(ex(0, 5'b11111, 0, 2'b10, 2'b10));
    v.push_back(mk(7, 7, 0, 0, 0, 7, 1, 7, 0, 0, 1, 0, 0)); e.push_back(ex(0, 5'b11111, 0, 2'b01, 2'b01));
    v.push_back(mk(7, 7, 0, 0, 0, 7, 0, 7, 0, 0, 1, 0, 0)); e.push_back(ex(0, 5'b11111, 0, 2'b00, 2'b00));
    v.push_back(mk(9, 7, 0, 0, 0, 9, 1, 7, 1, 0, 1, 0, 0)); e.push_back(ex(0, 5'b11111, 0, 2'b01, 2'b10));
    v.push_back(mk(9, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(0, 5'b11111, 0, 2'b00, 2'b00));
    for (int i = 0; i < v.size(); i++) begin
      in0 = v[i]; push_exp(0, "fwd", e[i]);
      @(negedge clk);
      s = sbq.pop_front(); got = (s.sel != 0) ? obs1 : obs0;
      ntest++;
      if (got !== s.o) begin nfail++; $display("FAIL %s[%0d] got %h expected %h", s.nm, i, got, s.o); end
      @(posedge clk); #1;
    end
    in0 = IDLE;
  endtask

  task automatic test_load_use();
    in_t v[$]; obs_t e[$]; sb_t s; obs_t got;
    v.push_back(mk(5, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(0, 5'b00111, 2'b01, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(0, 5'b11111, 2'b00, 0, 0));
    v.push_back(IDLE);                                      e.push_back(ex(0, 5'b00111, 2'b00, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      in0 = v[i]; push_exp(0, "load_use", e[i]);
      @(negedge clk);
      s = sbq.pop_front(); got = (s.sel != 0) ? obs1 : obs0;
      ntest++;
      if (got !== s.o) begin nfail++; $display("FAIL %s[%0d] got %h expected %h", s.nm, i, got, s.o); end
      @(posedge clk); #1;
    end
    in0 = IDLE;
  endtask

  task automatic test_stall_only();
    in_t v[$]; obs_t e[$]; sb_t s; obs_t got;
    v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b00111, 2'b01, 0, 0));
    v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b01, 5'b00111, 2'b01, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b11111, 2'b00, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b11111, 2'b00, 0, 0));
    v.push_back(mk(0, 4, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b00111, 2'b01, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b11111, 2'b00, 0, 0));
    v.push_back(mk(6, 0, 0, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b00111, 2'b01, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b11111, 2'b00, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      in1 = v[i]; push_exp(1, "stall_only", e[i]);
      @(negedge clk);
      s = sbq.pop_front(); got = (s.sel != 0) ? obs1 : obs0;
      ntest++;
      if (got !== s.o) begin nfail++; $display("FAIL %s[%0d] got %h expected %h", s.nm, i, got, s.o); end
      @(posedge clk); #1;
    end
    in1 = IDLE;
  endtask

  task automatic test_branch_in_stall();
    in_t v[$]; obs_t e[$]; sb_t s; obs_t got;
    v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b00111, 2'b01, 0, 0));
    v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0)); e.push_back(ex(2'b01, 5'b11111, 2'b11, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b11111, 2'b00, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      in1 = v[i]; push_exp(1, "branch_in_stall", e[i]);
      @(negedge clk);
      s = sbq.pop_front(); got = (s.sel != 0) ? obs1 : obs0;
      ntest++;
      if (got !== s.o) begin nfail++; $display("FAIL %s[%0d] got %h expected %h", s.nm, i, got, s.o); end
      @(posedge clk); #1;
    end
    in1 = IDLE;
  endtask

  task automatic test_flushpend();
    in_t v[$]; obs_t e[$]; sb_t s; obs_t got;
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(ex(2'b00, 5'b00111, 2'b00, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(ex(2'b11, 5'b00111, 2'b00, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b11, 5'b11111, 2'b11, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b11111, 2'b00, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      in0 = v[i]; push_exp(0, "flushpend", e[i]);
      @(negedge clk);
      s = sbq.pop_front(); got = (s.sel != 0) ? obs1 : obs0;
      ntest++;
      if (got !== s.o) begin nfail++; $display("FAIL %s[%0d] got %h expected %h", s.nm, i, got, s.o); end
      @(posedge clk); #1;
    end
    in0 = IDLE;
  endtask

  task automatic test_memwait();
    in_t v[$]; obs_t e[$]; sb_t s; obs_t got;
    v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b00111, 2'b01, 0, 0));
    v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(ex(2'b01, 5'b00000, 2'b00, 0, 0));
    v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(ex(2'b10, 5'b00000, 2'b00, 0, 0));
    v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(ex(2'b10, 5'b00000, 2'b00, 0, 0));
    v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1)); e.push_back(ex(2'b10, 5'b00111, 2'b01, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b11111, 2'b00, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0)); e.push_back(ex(2'b00, 5'b00000, 2'b00, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1)); e.push_back(ex(2'b10, 5'b11111, 2'b11, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b11111, 2'b00, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      in1 = v[i]; push_exp(1, "memwait", e[i]);
      @(negedge clk);
      s = sbq.pop_front(); got = (s.sel != 0) ? obs1 : obs0;
      ntest++;
      if (got !== s.o) begin nfail++; $display("FAIL %s[%0d] got %h expected %h", s.nm, i, got, s.o); end
      @(posedge clk); #1;
    end
    in1 = IDLE;
  endtask

  // A persistent ID/EX hazard bubbles every cycle, driving the 4-bit counter into saturation.
  task automatic test_saturate();
    in_t v[$]; obs_t e[$]; sb_t s; obs_t got;
    for (int i = 0; i < 20; i++) begin
      v.push_back(mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      e.push_back(ex((i % 2 != 0) ? 2'b01 : 2'b00, 5'b00111, 2'b01, 0, 0));
    end
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(ex(2'b00, 5'b11111, 2'b00, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      in1 = v[i]; push_exp(1, "saturate", e[i]);
      @(negedge clk);
      s = sbq.pop_front(); got = (s.sel != 0) ? obs1 : obs0;
      ntest++;
      if (got !== s.o) begin nfail++; $display("FAIL %s[%0d] got %h expected %h", s.nm, i, got, s.o); end
      @(posedge clk); #1;
    end
    in1 = IDLE;
  endtask

  task automatic test_reset_mid_stall();
    sb_t s; obs_t got;
    in1 = mk(3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    push_exp(1, "rst_mid_pre", ex(2'b00, 5'b00111, 2'b01, 0, 0));
    @(negedge clk);
    s = sbq.pop_front(); got = obs1; ntest++;
    if (got !== s.o) begin nfail++; $display("FAIL %s got %h expected %h", s.nm, got, s.o); end
    @(posedge clk); #1;
    nRST = 1'b0; mbub[0] = 0; mbub[1] = 0;
    push_exp(1, "rst_mid_hold", ex(2'b00, 5'b00000, 2'b00, 0, 0));
    @(negedge clk);
    s = sbq.pop_front(); got = obs1; ntest++;
    if (got !== s.o) begin nfail++; $display("FAIL %s got %h expected %h", s.nm, got, s.o); end
    @(posedge clk); #1;
    nRST = 1'b1; in1 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      push_exp(1, "rst_mid_after", ex(2'b00, 5'b11111, 2'b00, 0, 0));
      @(negedge clk);
      s = sbq.pop_front(); got = obs1; ntest++;
      if (got !== s.o) begin nfail++; $display("FAIL %s[%0d] got %h expected %h", s.nm, i, got, s.o); end
      @(posedge clk); #1;
    end
    in1 = IDLE;
  endtask

  initial begin
    in0 = IDLE;
    in1 = IDLE;
    test_reset();
    test_fwd();
    test_load_use();
    test_stall_only();
    test_branch_in_stall();
    test_flushpend();
    test_memwait();
    test_saturate();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
